// File: rtl/ikun_vip_pkg.sv
// ikun_vip_pkg: shared box record and FSM state types for the motion-box extractor
package ikun_vip_pkg;
   localparam int BOX_AW = 11;
   localparam int BOX_CW = 21;
   typedef enum logic {WAIT_SOF, IN_FRAME} state_t;
   typedef struct packed {
      logic              found;
      logic [BOX_AW-1:0] xmin;
      logic [BOX_AW-1:0] xmax;
      logic [BOX_AW-1:0] ymin;
      logic [BOX_AW-1:0] ymax;
      logic [BOX_CW-1:0] count;
   } bbox_t;
endpackage

// File: rtl/ikun_minmax_acc.sv
// ikun_minmax_acc: per-axis min/max tracker; load restarts it, next values are exposed for same-cycle commit
module ikun_minmax_acc #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_upd,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_min,
   output logic [W-1:0] o_max,
   output logic [W-1:0] o_min_nxt,
   output logic [W-1:0] o_max_nxt
);
   logic [W-1:0] r_min, r_max, w_min_base, w_max_base;
   assign w_min_base = i_load ? '1 : r_min;
   assign w_max_base = i_load ? '0 : r_max;
   assign o_min_nxt  = (i_upd && i_val < w_min_base) ? i_val : w_min_base;
   assign o_max_nxt  = (i_upd && i_val > w_max_base) ? i_val : w_max_base;
   assign o_min      = r_min;
   assign o_max      = r_max;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_min <= '0;
         r_max <= '0;
      end else begin
         r_min <= o_min_nxt;
         r_max <= o_max_nxt;
      end
   end
endmodule

// File: rtl/ikun_bbox_extract.sv
// ikun_bbox_extract: per-frame motion bounding box and pixel count from a 1-bit mask stream
module ikun_bbox_extract
   import ikun_vip_pkg::*;
#(
   parameter int AW         = BOX_AW,
   parameter int DW         = 1,
   parameter int COLS       = 1280,
   parameter int ROWS       = 720,
   parameter int CW         = BOX_CW,
   parameter int MIN_PIXELS = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_axis_video_tdata,
   input  logic          s_axis_video_tvalid,
   output logic          s_axis_video_tready,
   input  logic          s_axis_video_tlast,
   input  logic          s_axis_video_tuser,
   output logic          m_box_valid,
   input  logic          m_box_ready,
   output logic          m_box_found,
   output logic [AW-1:0] m_box_xmin,
   output logic [AW-1:0] m_box_xmax,
   output logic [AW-1:0] m_box_ymin,
   output logic [AW-1:0] m_box_ymax,
   output logic [CW-1:0] m_box_count,
   output logic          frame_err
);
   localparam logic [AW-1:0] X_LAST = AW'(COLS - 1);
   localparam logic [AW-1:0] Y_LAST = AW'(ROWS - 1);
   state_t        r_state;
   logic          r_tready, r_err_line, r_valid, r_ferr;
   logic [AW-1:0] r_x, r_y;
   logic [CW-1:0] r_cnt;
   bbox_t         r_rec;
   logic          w_fire, w_sof, w_act, w_fg, w_err, w_eof, w_found;
   logic [AW-1:0] w_bx, w_by;
   logic [AW-1:0] w_xmin, w_xmax, w_ymin, w_ymax, w_xmin_n, w_xmax_n, w_ymin_n, w_ymax_n;
   logic [CW-1:0] w_cnt_base, w_cnt_nxt;
   bbox_t         w_rec;
   assign w_fire     = s_axis_video_tvalid & r_tready;
   assign w_sof      = w_fire & s_axis_video_tuser;
   assign w_act      = w_fire & (w_sof | (r_state == IN_FRAME));
   assign w_fg       = w_act & s_axis_video_tdata[0];
   assign w_bx       = w_sof ? '0 : r_x;
   assign w_by       = w_sof ? '0 : r_y;
   // a beat at the last column without tlast means the line overruns
   assign w_err      = (~w_sof & r_err_line) | (s_axis_video_tlast ^ (w_bx == X_LAST));
   assign w_eof      = w_act & s_axis_video_tlast & (w_by == Y_LAST);
   assign w_cnt_base = w_sof ? '0 : r_cnt;
   assign w_cnt_nxt  = w_cnt_base + CW'(w_fg & ~&w_cnt_base);
   assign w_found    = w_cnt_nxt >= CW'(MIN_PIXELS);
   assign w_rec      = '{w_found, w_found ? w_xmin_n : '0, w_found ? w_xmax_n : '0,
                         w_found ? w_ymin_n : '0, w_found ? w_ymax_n : '0, w_cnt_nxt};
   ikun_minmax_acc #(.W(AW)) u_acc_x (
      .clk(clk), .rst(rst), .i_load(w_sof), .i_upd(w_fg), .i_val(w_bx),
      .o_min(w_xmin), .o_max(w_xmax), .o_min_nxt(w_xmin_n), .o_max_nxt(w_xmax_n)
   );
   ikun_minmax_acc #(.W(AW)) u_acc_y (
      .clk(clk), .rst(rst), .i_load(w_sof), .i_upd(w_fg), .i_val(w_by),
      .o_min(w_ymin), .o_max(w_ymax), .o_min_nxt(w_ymin_n), .o_max_nxt(w_ymax_n)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= WAIT_SOF;
         r_tready   <= 1'b0;
         r_x        <= '0;
         r_y        <= '0;
         r_err_line <= 1'b0;
         r_cnt      <= '0;
         r_rec      <= '0;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_tready <= 1'b1;
         r_ferr   <= (w_sof & (r_state == IN_FRAME)) | (w_eof & (w_err | (r_valid & ~m_box_ready)));
         if (w_act) begin
            r_x        <= s_axis_video_tlast ? '0 : ((w_bx == X_LAST) ? w_bx : w_bx + 1'b1);
            r_y        <= s_axis_video_tlast ? w_by + 1'b1 : w_by;
            r_err_line <= w_err;
            r_cnt      <= w_cnt_nxt;
            r_state    <= w_eof ? WAIT_SOF : IN_FRAME;
         end
         if (w_eof) begin
            r_rec   <= w_rec;
            r_valid <= 1'b1;
         end else if (m_box_ready) begin
            r_valid <= 1'b0;
         end
      end
   end
   assign s_axis_video_tready = r_tready;
   assign m_box_valid         = r_valid;
   assign m_box_found         = r_rec.found;
   assign m_box_xmin          = r_rec.xmin;
   assign m_box_xmax          = r_rec.xmax;
   assign m_box_ymin          = r_rec.ymin;
   assign m_box_ymax          = r_rec.ymax;
   assign m_box_count         = r_rec.count;
   assign frame_err           = r_ferr;
endmodule

// File: tb/tb_ikun_bbox_extract.sv
// tb_ikun_bbox_extract: randomized frames on an 8x4 raster checked against a mask-level box model
module tb_ikun_bbox_extract;
   logic        clk = 1'b0, rst = 1'b1;
   logic [0:0]  tdata = 1'b0;
   logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, ready = 1'b1;
   logic        tready, valid, found, ferr;
   logic [10:0] xmin, xmax, ymin, ymax;
   logic [20:0] count;
   logic [65:0] cur;
   logic [65:0] got_q[$];
   int          total = 0, bad = 0, n_err = 0, err_base = 0, got_rd = 0;
   always #5 clk = ~clk;
   ikun_bbox_extract #(.AW(11), .DW(1), .COLS(8), .ROWS(4), .CW(21), .MIN_PIXELS(2)) dut (
      .clk(clk), .rst(rst),
      .s_axis_video_tdata(tdata), .s_axis_video_tvalid(tvalid), .s_axis_video_tready(tready),
      .s_axis_video_tlast(tlast), .s_axis_video_tuser(tuser),
      .m_box_valid(valid), .m_box_ready(ready), .m_box_found(found),
      .m_box_xmin(xmin), .m_box_xmax(xmax), .m_box_ymin(ymin), .m_box_ymax(ymax),
      .m_box_count(count), .frame_err(ferr)
   );
   assign cur = {found, xmin, xmax, ymin, ymax, count};
   always @(negedge clk) begin
      if (valid && ready) got_q.push_back(cur);
      if (ferr) n_err++;
   end
   task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic beat(input logic d, input logic l, input logic u, input bit gaps);
      int g = gaps ? $urandom_range(0, 2) : 0;
      repeat (g) begin
         tvalid = 1'b0;
         tdata  = 1'($urandom);
         tlast  = 1'($urandom);
         tuser  = 1'($urandom);
         step();
      end
      tvalid = 1'b1;
      tdata  = d;
      tlast  = l;
      tuser  = u;
      step();
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
   endtask
   task automatic send_frame(input logic [31:0] m, input bit gaps, input int sl, input int slen, input int stop);
      int n = 0;
      for (int y = 0; y < 4; y++) begin
         int len = (y == sl) ? slen : 8;
         for (int x = 0; x < len; x++) begin
            if (n < stop) beat(m[y*8+x], x == len - 1, x == 0 && y == 0, gaps);
            n++;
         end
      end
   endtask
   function automatic logic [65:0] model(input logic [31:0] m, input int sl, input int slen);
      int c = 0, x0 = 99, x1 = -1, y0 = 99, y1 = -1;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 8; x++)
            if (m[y*8+x] && !(y == sl && x >= slen)) begin
               c++;
               if (x < x0) x0 = x;
               if (x > x1) x1 = x;
               if (y < y0) y0 = y;
               if (y > y1) y1 = y;
            end
      if (c < 2) return {1'b0, 44'd0, 21'(c)};
      return {1'b1, 11'(x0), 11'(x1), 11'(y0), 11'(y1), 21'(c)};
   endfunction
   task automatic expect_rec(input string tag, input logic [65:0] exp, input int errs);
      repeat (4) step();
      chk({tag, "_n"}, 66'(got_q.size() - got_rd), 66'd1);
      if (got_q.size() > got_rd) chk(tag, got_q[got_rd], exp);
      chk({tag, "_err"}, 66'(n_err - err_base), 66'(errs));
      chk({tag, "_vdrop"}, 66'(valid), 66'd0);
      got_rd   = got_q.size();
      err_base = n_err;
   endtask
   initial begin
      logic [31:0] m1, ma, mb, mc, md, mr;
      logic [65:0] r1;
      int          sl, slen;
      m1 = (32'd1 << 10) | (32'd1 << 29);
      r1 = {1'b1, 11'd2, 11'd5, 11'd1, 11'd3, 21'd2};
      repeat (3) step();
      chk("rst_tready", 66'(tready), 66'd0);
      chk("rst_flags", 66'({valid, ferr}), 66'd0);
      chk("rst_rec", cur, 66'd0);
      rst = 1'b0;
      step();
      chk("tready_up", 66'(tready), 66'd1);
      send_frame(m1, 1'b0, -1, 0, 32);
      chk("t1_lat", 66'(valid), 66'd1);
      chk("t1_now", cur, r1);
      expect_rec("t1", r1, 0);
      send_frame(32'd0, 1'b0, -1, 0, 32);
      expect_rec("t2", 66'd0, 0);
      ready = 1'b0;
      ma = $urandom;
      mb = $urandom;
      send_frame(ma, 1'b0, -1, 0, 32);
      step();
      chk("t3_held_a", cur, model(ma, -1, 0));
      chk("t3_valid_a", 66'(valid), 66'd1);
      send_frame(mb, 1'b0, -1, 0, 32);
      step();
      chk("t3_held_b", cur, model(mb, -1, 0));
      chk("t3_none_yet", 66'(got_q.size() - got_rd), 66'd0);
      ready = 1'b1;
      expect_rec("t3", model(mb, -1, 0), 1);
      send_frame($urandom, 1'b0, -1, 0, 19);
      mc = $urandom;
      send_frame(mc, 1'b0, -1, 0, 32);
      expect_rec("t4", model(mc, -1, 0), 1);
      md = $urandom;
      send_frame(md, 1'b0, 1, 6, 32);
      chk("t5_ferr_now", 66'(ferr), 66'd1);
      expect_rec("t5", model(md, 1, 6), 1);
      send_frame(m1, 1'b1, -1, 0, 32);
      expect_rec("t6_gap", r1, 0);
      send_frame($urandom, 1'b1, -1, 0, 13);
      rst = 1'b1;
      step();
      step();
      chk("t6_rst_tready", 66'(tready), 66'd0);
      chk("t6_rst_valid", 66'(valid), 66'd0);
      chk("t6_rst_rec", cur, 66'd0);
      rst = 1'b0;
      repeat (6) step();
      chk("t6_no_rec", 66'(got_q.size() - got_rd), 66'd0);
      chk("t6_no_err", 66'(n_err - err_base), 66'd0);
      for (int i = 0; i < 8; i++) begin
         mr   = $urandom;
         sl   = $urandom_range(0, 4);
         slen = $urandom_range(1, 8);
         send_frame(mr, 1'b1, sl, slen, 32);
         expect_rec($sformatf("rnd%0d", i), model(mr, sl, slen), (sl < 4 && slen != 8) ? 1 : 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
